// File: rtl/exception_ctrl.sv
// exception_ctrl: LEGv8 exception/interrupt controller with ELR/ESR capture, IRQ handshake and nesting halt
module exception_ctrl #(
    parameter int            N      = 64,
    parameter logic [N-1:0]  VECTOR = 64'h0000_0000_0000_00D8,
    parameter int            CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       EStatus,
    input  logic             ExtIRQ,
    input  logic             ERet,
    input  logic [N-1:0]     PC,
    output logic             Exc,
    output logic [N-1:0]     ExcVector,
    output logic [N-1:0]     ELR,
    output logic [N-1:0]     ESR,
    output logic             ExtIAck,
    output logic             InHandler,
    output logic             Halt,
    output logic [CNT_W-1:0] ExcCount
);
    typedef enum logic [1:0] {RUN, HANDLER, HALTED} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_elr;
    logic [N-1:0]     r_esr;
    logic             r_iack;
    logic [CNT_W-1:0] r_cnt;
    logic             w_irq_pend;
    logic             w_sync_pend;
    logic             w_exc;

    assign w_irq_pend  = (EStatus == 4'b0001) && !r_iack;
    assign w_sync_pend = (EStatus != 4'b0000) && (EStatus != 4'b0001);

    // Exception decision and next state; a synchronous fault inside the handler is fatal and beats ERET
    always_comb begin
        w_exc  = !reset && (r_state == RUN) && (w_irq_pend || w_sync_pend);
        w_next = r_state;
        case (r_state)
            RUN:     w_next = w_exc ? HANDLER : RUN;
            HANDLER: w_next = w_sync_pend ? HALTED : (ERet ? RUN : HANDLER);
            default: w_next = HALTED;
        endcase
    end

    // State register plus capture of link/syndrome, saturating counter and IRQ acknowledge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_elr   <= '0;
            r_esr   <= '0;
            r_iack  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_exc) begin
                r_elr <= PC;
                r_esr <= {{(N-4){1'b0}}, EStatus};
                r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
            end
            if (w_exc && w_irq_pend)
                r_iack <= 1'b1;
            else if (!ExtIRQ)
                r_iack <= 1'b0;
        end
    end

    assign Exc       = w_exc;
    assign ExcVector = VECTOR;
    assign ELR       = r_elr;
    assign ESR       = r_esr;
    assign ExtIAck   = r_iack;
    assign InHandler = (r_state == HANDLER);
    assign Halt      = (r_state == HALTED);
    assign ExcCount  = r_cnt;
endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: table-driven directed checks of exception_ctrl
module tb_exception_ctrl;
    logic        clk;
    logic        reset;
    logic [3:0]  EStatus;
    logic        ExtIRQ;
    logic        ERet;
    logic [63:0] PC;
    logic        Exc;
    logic [63:0] ExcVector;
    logic [63:0] ELR;
    logic [63:0] ESR;
    logic        ExtIAck;
    logic        InHandler;
    logic        Halt;
    logic [7:0]  ExcCount;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  es;
        logic        irq;
        logic        eret;
        logic [63:0] pc;
        logic        exc;
        logic [63:0] elr;
        logic [63:0] esr;
        logic        iack;
        logic        inh;
        logic        halt;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[23];

    exception_ctrl dut (
        .clk(clk), .reset(reset), .EStatus(EStatus), .ExtIRQ(ExtIRQ), .ERet(ERet), .PC(PC),
        .Exc(Exc), .ExcVector(ExcVector), .ELR(ELR), .ESR(ESR), .ExtIAck(ExtIAck),
        .InHandler(InHandler), .Halt(Halt), .ExcCount(ExcCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic [3:0] es, logic irq, logic eret, logic [63:0] pc,
                                logic exc, logic [63:0] elr, logic [63:0] esr, logic iack,
                                logic inh, logic halt, logic [7:0] cnt);
        vec_t v;
        v.rst = rst; v.es = es; v.irq = irq; v.eret = eret; v.pc = pc;
        v.exc = exc; v.elr = elr; v.esr = esr; v.iack = iack; v.inh = inh; v.halt = halt; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        reset = t.rst; EStatus = t.es; ExtIRQ = t.irq; ERet = t.eret; PC = t.pc;
        #1;
        chk("Exc", idx, {63'b0, Exc}, {63'b0, t.exc});
        @(posedge clk);
        #1;
        chk("ELR", idx, ELR, t.elr);
        chk("ESR", idx, ESR, t.esr);
        chk("ExtIAck", idx, {63'b0, ExtIAck}, {63'b0, t.iack});
        chk("InHandler", idx, {63'b0, InHandler}, {63'b0, t.inh});
        chk("Halt", idx, {63'b0, Halt}, {63'b0, t.halt});
        chk("ExcCount", idx, {56'b0, ExcCount}, {56'b0, t.cnt});
    endtask

    initial begin
        reset = 1'b1; EStatus = 4'd0; ExtIRQ = 1'b0; ERet = 1'b0; PC = 64'd0;
        //              rst es   irq eret pc       exc elr       esr  iack inh halt cnt
        tbl[0]  = mk(1, 4'd0, 0, 0, 64'h000, 0, 64'h000, 64'h0, 0, 0, 0, 8'd0);
        tbl[1]  = mk(0, 4'd2, 0, 0, 64'h040, 1, 64'h040, 64'h2, 0, 1, 0, 8'd1);
        tbl[2]  = mk(0, 4'd0, 0, 1, 64'h044, 0, 64'h040, 64'h2, 0, 0, 0, 8'd1);
        tbl[3]  = mk(0, 4'd1, 1, 0, 64'h100, 1, 64'h100, 64'h1, 1, 1, 0, 8'd2);
        tbl[4]  = mk(0, 4'd1, 1, 0, 64'h104, 0, 64'h100, 64'h1, 1, 1, 0, 8'd2);
        tbl[5]  = mk(0, 4'd1, 1, 1, 64'h108, 0, 64'h100, 64'h1, 1, 0, 0, 8'd2);
        tbl[6]  = mk(0, 4'd1, 1, 0, 64'h100, 0, 64'h100, 64'h1, 1, 0, 0, 8'd2);
        tbl[7]  = mk(0, 4'd0, 0, 0, 64'h104, 0, 64'h100, 64'h1, 0, 0, 0, 8'd2);
        tbl[8]  = mk(0, 4'd1, 1, 0, 64'h200, 1, 64'h200, 64'h1, 1, 1, 0, 8'd3);
        tbl[9]  = mk(0, 4'd0, 0, 0, 64'h0D8, 0, 64'h200, 64'h1, 0, 1, 0, 8'd3);
        tbl[10] = mk(0, 4'd2, 0, 0, 64'h080, 0, 64'h200, 64'h1, 0, 0, 1, 8'd3);
        tbl[11] = mk(0, 4'd0, 0, 1, 64'h084, 0, 64'h200, 64'h1, 0, 0, 1, 8'd3);
        tbl[12] = mk(0, 4'd2, 0, 0, 64'h088, 0, 64'h200, 64'h1, 0, 0, 1, 8'd3);
        tbl[13] = mk(0, 4'd1, 1, 0, 64'h08C, 0, 64'h200, 64'h1, 0, 0, 1, 8'd3);
        tbl[14] = mk(1, 4'd0, 0, 0, 64'h090, 0, 64'h000, 64'h0, 0, 0, 0, 8'd0);
        tbl[15] = mk(0, 4'd2, 0, 1, 64'h300, 1, 64'h300, 64'h2, 0, 1, 0, 8'd1);
        tbl[16] = mk(0, 4'd0, 0, 1, 64'h0D8, 0, 64'h300, 64'h2, 0, 0, 0, 8'd1);
        tbl[17] = mk(0, 4'd0, 0, 1, 64'h304, 0, 64'h300, 64'h2, 0, 0, 0, 8'd1);
        tbl[18] = mk(0, 4'd2, 0, 0, 64'h400, 1, 64'h400, 64'h2, 0, 1, 0, 8'd2);
        tbl[19] = mk(0, 4'd2, 0, 1, 64'h500, 0, 64'h400, 64'h2, 0, 0, 1, 8'd2);
        tbl[20] = mk(1, 4'd2, 0, 0, 64'h504, 0, 64'h000, 64'h0, 0, 0, 0, 8'd0);
        tbl[21] = mk(0, 4'd1, 0, 0, 64'h600, 1, 64'h600, 64'h1, 1, 1, 0, 8'd1);
        tbl[22] = mk(0, 4'd0, 0, 1, 64'h0D8, 0, 64'h600, 64'h1, 0, 0, 0, 8'd1);

        chk("ExcVector", -1, ExcVector, 64'h0000_0000_0000_00D8);
        for (int i = 0; i < 23; i++) apply(tbl[i], i);

        apply(mk(1, 4'd0, 0, 0, 64'h0, 0, 64'h0, 64'h0, 0, 0, 0, 8'd0), 100);
        for (int k = 1; k <= 256; k++) begin
            logic [7:0] c;
            c = (k > 255) ? 8'd255 : k[7:0];
            apply(mk(0, 4'd2, 0, 0, 64'(k * 4), 1, 64'(k * 4), 64'h2, 0, 1, 0, c), 100 + 2 * k);
            apply(mk(0, 4'd0, 0, 1, 64'h0D8, 0, 64'(k * 4), 64'h2, 0, 0, 0, c), 101 + 2 * k);
        end
        apply(mk(0, 4'd2, 0, 0, 64'h700, 1, 64'h700, 64'h2, 0, 1, 0, 8'd255), 700);
        apply(mk(1, 4'd1, 1, 0, 64'h704, 0, 64'h000, 64'h0, 0, 0, 0, 8'd0), 701);
        apply(mk(0, 4'd1, 1, 0, 64'h800, 1, 64'h800, 64'h1, 1, 1, 0, 8'd1), 702);
        apply(mk(1, 4'd0, 1, 0, 64'h804, 0, 64'h000, 64'h0, 0, 0, 0, 8'd0), 703);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
